// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response channel of the MEM-stage load/store unit.
// The pipeline is the master; the access unit is the slave.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-only data RAM.
// Sub-word stores are done as read-modify-write; bad requests answer with an error pulse.
module mem_access_unit #(
  parameter int MEM_WORDS  = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  mem_access_unit_if.slave    bus,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [31:0]         mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        lat_write;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        req_error;
  logic [1:0]  req_lane;

  assign bus.req_ready = ~reset & ((state == IDLE) | (state == RESP));
  assign accept        = bus.req_valid & bus.req_ready;
  // Lane is stored already endian-mapped; bit 1 of it is the half lane in both modes.
  assign req_lane      = BIG_ENDIAN ? ~bus.req_address[1:0] : bus.req_address[1:0];

  always_comb begin
    req_error = 1'b0;
    case (bus.req_size)
      2'b01:   req_error = bus.req_address[0];
      2'b10:   req_error = (bus.req_address[1:0] != 2'b00);
      2'b11:   req_error = 1'b1;
      default: req_error = 1'b0;
    endcase
    if (bus.req_address[31:2] >= 30'(MEM_WORDS))
      req_error = 1'b1;
  end

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_value = {{24{~uns & b[7]}}, b};
      2'b01:   load_value = {{16{~uns & h[15]}}, h};
      default: load_value = word;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    if (size == 2'b00)
      m[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return m;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_write      <= 1'b0;
      lat_unsigned   <= 1'b0;
      lat_size       <= 2'b00;
      lat_lane       <= 2'b00;
      lat_wdata      <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_error <= 1'b0;
          mem_read       <= 1'b0;
          mem_write      <= 1'b0;
          mem_write_data <= '0;
          state          <= IDLE;
          if (accept) begin
            lat_write    <= bus.req_write;
            lat_unsigned <= bus.req_unsigned;
            lat_size     <= bus.req_size;
            lat_lane     <= req_lane;
            lat_wdata    <= bus.req_wdata;
            if (req_error) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (!bus.req_write || bus.req_size != 2'b10) begin
              state       <= READ;
              mem_read    <= 1'b1;
              mem_address <= {bus.req_address[31:2], 2'b00};
            end else begin
              state          <= WRITE;
              mem_write      <= 1'b1;
              mem_write_data <= bus.req_wdata;
              mem_address    <= {bus.req_address[31:2], 2'b00};
            end
          end
        end
        READ: begin
          mem_read <= 1'b0;
          if (!lat_write) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= load_value(mem_read_data, lat_size, lat_unsigned, lat_lane);
          end else begin
            state          <= WRITE;
            mem_write      <= 1'b1;
            mem_write_data <= merge_word(mem_read_data, lat_wdata, lat_size, lat_lane);
          end
        end
        WRITE: begin
          mem_write      <= 1'b0;
          mem_write_data <= '0;
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_error <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word RAM model standing in for datamem.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  int          wr_count = 0;
  int          rd_count = 0;
  int          both_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  logic [31:0] ram [32];

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_WORDS(32), .BIG_ENDIAN(1'b0)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_write) ram[mem_address[6:2]] <= mem_write_data;

  assign mem_read_data = mem_read ? ram[mem_address[6:2]] : 32'h0;

  // Bus activity seen mid-cycle, used by the tests as before/after deltas.
  always @(negedge clock) begin
    if (mem_write) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_address;
      last_wr_data <= mem_write_data;
    end
    if (mem_read) rd_count <= rd_count + 1;
    if (mem_read && mem_write) both_count <= both_count + 1;
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int waitc;
    lat = -1; rd = '0; er = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_address = a; bus.req_wdata = d;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout addr=%h ready=%b required=1", a, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_error;
        break;
      end
    end
    #2;
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++;
    if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b required=0", bus.req_ready); end
    total++;
    if ({mem_write, mem_read, bus.resp_valid, bus.resp_error} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b required=0000", {mem_write, mem_read, bus.resp_valid, bus.resp_error});
    end
    total++;
    if ({mem_address, mem_write_data, bus.resp_rdata} !== 96'h0) begin
      bad++; $display("[TB] FAIL reset_data got=%h/%h/%h required=0", mem_address, mem_write_data, bus.resp_rdata);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_reset got=%b required=1", bus.req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er; int w0, r0;
    w0 = wr_count; r0 = rd_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, lat, rd, er);
    total++;
    if (lat !== 2) begin bad++; $display("[TB] FAIL sw_latency got=%0d required=2", lat); end
    total++;
    if (wr_count - w0 !== 1 || rd_count - r0 !== 0) begin
      bad++; $display("[TB] FAIL sw_bus writes=%0d reads=%0d required=1/0", wr_count - w0, rd_count - r0);
    end
    total++;
    if (last_wr_addr !== 32'h08 || last_wr_data !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL sw_word addr=%h data=%h required=00000008/deadbeef", last_wr_addr, last_wr_data);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("[TB] FAIL lw_after_sw lat=%0d data=%h err=%b required=2/deadbeef/0", lat, rd, er);
    end
  endtask

  task automatic test_subword_loads();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        us [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h0B, 32'h0B, 32'h08, 32'h0A};
    logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    int lat; logic [31:0] rd; logic er;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], us[i], ad[i], 32'h0, lat, rd, er);
      total++;
      if (lat !== 2 || rd !== ex[i] || er !== 1'b0) begin
        bad++; $display("[TB] FAIL subload_%0d lat=%0d data=%h err=%b required=2/%h/0", i, lat, rd, er, ex[i]);
      end
    end
  endtask

  task automatic test_subword_stores();
    int lat; logic [31:0] rd; logic er; int w0, r0;
    w0 = wr_count; r0 = rd_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hAAAAAA11, lat, rd, er);
    total++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("[TB] FAIL sb_resp lat=%0d data=%h err=%b required=3/0/0", lat, rd, er);
    end
    total++;
    if (wr_count - w0 !== 1 || rd_count - r0 !== 1 || last_wr_data !== 32'hDEAD11EF) begin
      bad++; $display("[TB] FAIL sb_rmw writes=%0d reads=%0d data=%h required=1/1/dead11ef",
                      wr_count - w0, rd_count - r0, last_wr_data);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'hBBBB1234, lat, rd, er);
    total++;
    if (lat !== 3 || last_wr_data !== 32'h123411EF || last_wr_addr !== 32'h08) begin
      bad++; $display("[TB] FAIL sh_rmw lat=%0d data=%h addr=%h required=3/123411ef/00000008", lat, last_wr_data, last_wr_addr);
    end
  endtask

  task automatic test_errors();
    logic        wr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h05, 32'h06, 32'h08, 32'h80};
    int lat; logic [31:0] rd; logic er; int w0, r0;
    w0 = wr_count; r0 = rd_count;
    for (int i = 0; i < 4; i++) begin
      do_req(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, lat, rd, er);
      total++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
        bad++; $display("[TB] FAIL error_%0d lat=%0d err=%b data=%h required=1/1/0", i, lat, er, rd);
      end
    end
    total++;
    if (wr_count - w0 !== 0 || rd_count - r0 !== 0) begin
      bad++; $display("[TB] FAIL error_bus writes=%0d reads=%0d required=0/0", wr_count - w0, rd_count - r0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h123411EF || er !== 1'b0) begin
      bad++; $display("[TB] FAIL ram_unchanged data=%h err=%b required=123411ef/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_address = 32'h00; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1 bus.req_write = 1'b0; bus.req_wdata = 32'h0;
    @(negedge clock);
    total++;
    if (mem_write !== 1'b1) begin bad++; $display("[TB] FAIL b2b_write got=%b required=1", mem_write); end
    @(negedge clock);
    total++;
    if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_resp valid=%b ready=%b required=1/1", bus.resp_valid, bus.req_ready);
    end
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    total++;
    if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL b2b_no_gap mem_read=%b required=1", mem_read); end
    @(negedge clock);
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFEF00D) begin
      bad++; $display("[TB] FAIL b2b_load valid=%b data=%h required=1/cafef00d", bus.resp_valid, bus.resp_rdata);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] rd; logic er; int w0; int seen;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_address = 32'h09; bus.req_wdata = 32'h55;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    total++;
    if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL midreset_in_read mem_read=%b required=1", mem_read); end
    #1;
    w0 = wr_count;
    reset = 1'b1;
    #1;
    total++;
    if ({mem_read, mem_write, bus.resp_valid, bus.req_ready} !== 4'b0000 || mem_address !== 32'h0) begin
      bad++; $display("[TB] FAIL midreset_outputs ctrl=%b addr=%h required=0000/0",
                      {mem_read, mem_write, bus.resp_valid, bus.req_ready}, mem_address);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.resp_valid) seen++;
    end
    #2;
    total++;
    if (seen !== 0 || wr_count - w0 !== 0) begin
      bad++; $display("[TB] FAIL midreset_dropped resp=%0d writes=%0d required=0/0", seen, wr_count - w0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'h123411EF || er !== 1'b0) begin
      bad++; $display("[TB] FAIL lw_after_reset lat=%0d data=%h err=%b required=2/123411ef/0", lat, rd, er);
    end
    total++;
    if (both_count !== 0) begin bad++; $display("[TB] FAIL read_write_overlap got=%0d required=0", both_count); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_address = '0; bus.req_wdata = '0;
    #2 reset = 1'b1;
    $display("[TB] start");
    test_reset();
    test_store_load();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
